// File: rtl/branch_spec_ctrl.sv
// Branch speculation controller: in-flight branch limiter, mispredict redirect/flush
// sequencer and predictor-update FIFO. Optional perf counters: BRANCH_SPEC_CTRL_PERF_EN.
module branch_spec_ctrl #(
  parameter int MAX_SPEC     = 4,
  parameter int UPD_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        debug_mode_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic        resolve_valid_i,
  input  logic        resolve_mispredict_i,
  input  logic        resolve_taken_i,
  input  logic [63:0] resolve_pc_i,
  input  logic [63:0] resolve_target_i,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic        flush_o,
  output logic        upd_valid_o,
  input  logic        upd_ready_i,
  output logic [63:0] upd_pc_o,
  output logic [63:0] upd_target_o,
  output logic        upd_taken_o,
  output logic [3:0]  outstanding_o
`ifdef BRANCH_SPEC_CTRL_PERF_EN
  ,
  output logic [31:0] perf_mispredict_o,
  output logic [31:0] perf_upd_drop_o
`endif
);

  localparam int AW  = $clog2(UPD_DEPTH);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AW:0] PTR_ONE = 1;

  // state    | meaning
  // IDLE     | normal operation, issue allowed while below MAX_SPEC
  // REDIRECT | one-cycle redirect pulse to the frontend
  // FLUSH    | squash window of FLUSH_CYCLES cycles
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [3:0]       out_q, out_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [63:0]      rpc_q, rpc_d;
  logic             issue_acc;

  assign issue_ready_o    = (state_q == IDLE) && (out_q < 4'(MAX_SPEC));
  assign issue_acc        = issue_valid_i && issue_ready_o;
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = rpc_q;
  assign flush_o          = (state_q != IDLE);
  assign outstanding_o    = out_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    fcnt_d  = fcnt_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        if (resolve_valid_i && resolve_mispredict_i) begin
          out_d   = '0;
          rpc_d   = resolve_target_i;
          state_d = REDIRECT;
        end else if (issue_acc && !resolve_valid_i) begin
          out_d = out_q + 4'd1;
        end else if (!issue_acc && resolve_valid_i && (out_q != '0)) begin
          out_d = out_q - 4'd1;
        end
      end
      REDIRECT: begin
        state_d = FLUSH;
        fcnt_d  = FCW'(FLUSH_CYCLES);
      end
      FLUSH: begin
        fcnt_d = fcnt_q - FCW'(1);
        if (fcnt_q <= FCW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // External flush overrides everything, including a redirect still pending.
    if (flush_i) begin
      state_d = IDLE;
      out_d   = '0;
      fcnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      fcnt_q  <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      fcnt_q  <= fcnt_d;
      rpc_q   <= rpc_d;
    end
  end

  logic [63:0] mem_pc  [UPD_DEPTH];
  logic [63:0] mem_tgt [UPD_DEPTH];
  logic        mem_tk  [UPD_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, push_req, push, pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_req = resolve_valid_i && !debug_mode_i && (state_q == IDLE);
  assign pop      = !empty && upd_ready_i;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  assign upd_valid_o  = !empty;
  assign upd_pc_o     = mem_pc[rd_q[AW-1:0]];
  assign upd_target_o = mem_tgt[rd_q[AW-1:0]];
  assign upd_taken_o  = mem_tk[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[wr_q[AW-1:0]]  <= resolve_pc_i;
      mem_tgt[wr_q[AW-1:0]] <= resolve_target_i;
      mem_tk[wr_q[AW-1:0]]  <= resolve_taken_i;
    end
  end

`ifdef BRANCH_SPEC_CTRL_PERF_EN
  logic [31:0] perf_mis_q, perf_drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_mis_q  <= '0;
      perf_drop_q <= '0;
    end else begin
      if ((state_q == REDIRECT) && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + 32'd1;
      if (push_req && full && !pop && (perf_drop_q != '1)) perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_mispredict_o = perf_mis_q;
  assign perf_upd_drop_o   = perf_drop_q;
`endif

`ifndef SYNTHESIS
  a_resolve_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((state_q == IDLE) && resolve_valid_i && !resolve_mispredict_i && !flush_i &&
      !issue_acc && (out_q == '0)))
    else $error("branch resolved with no branch outstanding");
`endif

endmodule

// File: doc/branch_spec_ctrl.md
Name: branch_spec_ctrl

Overview:
- Controller between the branch resolution logic, the issue stage and the frontend predictors.
- Limits the number of unresolved branches in flight and sequences misprediction recovery: registered redirect, then a fixed flush window.
- Queues resolved-branch records so the frontend predictor update port can be back-pressured.

Parameters:
MAX_SPEC, 4, max unresolved branches in flight (1..15)
UPD_DEPTH, 4, predictor-update FIFO depth (power of 2, >=2)
FLUSH_CYCLES, 2, cycles the flush window lasts after a redirect (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
flush_i  in  1  external pipeline flush (exception/fence)
debug_mode_i  in  1  core in debug mode; suppresses predictor updates
issue_valid_i  in  1  issue stage wants to issue a branch
issue_ready_o  out  1  branch may issue this cycle
resolve_valid_i  in  1  branch resolved this cycle
resolve_mispredict_i  in  1  resolved branch was mispredicted
resolve_taken_i  in  1  resolved branch taken
resolve_pc_i  in  64  PC of resolved branch
resolve_target_i  in  64  correct next PC (target or fall-through)
redirect_valid_o  out  1  frontend redirect pulse
redirect_pc_o  out  64  redirect address
flush_o  out  1  squash younger instructions in issue/frontend
upd_valid_o  out  1  predictor update record valid
upd_ready_i  in  1  frontend accepts update
upd_pc_o  out  64  update PC
upd_target_o  out  64  update target
upd_taken_o  out  1  update taken flag
outstanding_o  out  4  current unresolved branch count

Behaviour:
- Reset: rst_ni is asynchronous, active-low. State IDLE; outstanding, FIFO pointers, flush counter = 0. All outputs 0 except issue_ready_o = 1.
- States:
  - IDLE: normal operation.
  - REDIRECT: one cycle.
  - FLUSH: FLUSH_CYCLES cycles.
- issue_ready_o = (state==IDLE) && (outstanding < MAX_SPEC). Combinational; independent of issue_valid_i.
- An issue is accepted on issue_valid_i && issue_ready_o.
- Counter update in IDLE, for a resolve without mispredict:
  - accepted issue only: +1
  - resolve only: -1
  - both in the same cycle: unchanged
  - resolve with outstanding==0: counter stays 0 and the simulation assertion fires.
- Mispredict (resolve_valid_i && resolve_mispredict_i in IDLE):
  - outstanding cleared to 0; an issue accepted in the same cycle is discarded.
  - Latch redirect_pc = resolve_target_i.
  - Next state REDIRECT.
- REDIRECT:
  - redirect_valid_o = 1 and flush_o = 1 for exactly this cycle; redirect_pc_o valid.
  - Then enter FLUSH with the flush counter loaded to FLUSH_CYCLES.
- FLUSH:
  - flush_o = 1; counter decrements each cycle; leave for IDLE when it reaches 1.
  - resolve_valid_i is ignored in REDIRECT/FLUSH (younger branches already squashed).
- Redirect timing: redirect_valid_o rises exactly 1 cycle after the mispredict resolve. The first issue_ready_o=1 comes 1+1+FLUSH_CYCLES cycles after the resolve.
- flush_i:
  - Highest priority, any state: next state IDLE, outstanding 0, no redirect emitted, pending redirect dropped.
  - FIFO contents are kept (already-resolved branches are architecturally valid).
  - A resolve in the same cycle as flush_i is still pushed.
- Update FIFO push: resolve_valid_i && !debug_mode_i && state==IDLE. Mispredicted branches are pushed too.
  - Fields pushed: pc, target, taken.
- Update FIFO pop: upd_valid_o && upd_ready_i.
  - upd_valid_o = !empty; upd_* driven from the head entry, registered storage.
  - Earliest visibility: 1 cycle after push.
- FIFO full:
  - Push without a simultaneous pop is dropped and the FIFO is unchanged.
  - Push with a simultaneous pop while full is accepted.
  - Pointers wrap modulo UPD_DEPTH; an extra occupancy bit distinguishes full from empty.
- outstanding_o is the registered counter value.

Optional Feature:
BRANCH_SPEC_CTRL_PERF_EN:
- Defined: adds outputs perf_mispredict_o [31:0], counting redirects emitted, and perf_upd_drop_o [31:0], counting pushes dropped on full.
  - Both saturate at all-ones.
  - Reset to 0; not cleared by flush_i.
- Undefined: these ports and counters do not exist.

Test Plan:
- Issue 4 branches back-to-back with MAX_SPEC=4 -> outstanding_o=4, issue_ready_o=0. One resolve -> outstanding_o=3, issue_ready_o=1 next cycle.
- Issue and resolve in the same cycle at outstanding=2 -> outstanding_o stays 2.
- Mispredict with resolve_target_i=64'h8000_1000, FLUSH_CYCLES=2 -> redirect_valid_o=1 with redirect_pc_o=64'h8000_1000 one cycle later. flush_o=1 for 3 cycles. outstanding_o=0. issue_ready_o=1 on cycle 4 after the resolve.
- Hold upd_ready_i=0 and resolve 5 branches with UPD_DEPTH=4 -> 4 entries kept, 5th dropped (perf_upd_drop_o=1 with macro). Raise upd_ready_i -> records drain in order, one per cycle.
- Resolve with debug_mode_i=1 -> no FIFO push, upd_valid_o stays 0; outstanding still decrements.
- Assert flush_i during FLUSH with 2 FIFO entries queued -> next cycle IDLE, flush_o=0, issue_ready_o=1, both entries still delivered.
